// File: rtl/kv_tile_reader_if.sv
// kv_tile_reader_if
// Row stream from the tile reader to the attention datapath.
//   out_valid : out_data holds a row
//   out_data  : row payload, WIDTH bits
//   out_last  : marks the final row of the tile
//   out_ready : sink accepts the row when out_valid && out_ready
// master = producer (tile reader), slave = consumer (datapath).
interface kv_tile_reader_if #(
    parameter int WIDTH = 32
);
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/kv_tile_reader.sv
// kv_tile_reader
// Streams a contiguous run of SRAM rows (K or V vectors) to the attention
// datapath over a valid/ready interface, one row per cycle when unstalled.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   start                : begin a tile (sampled only when idle)
//   base_addr, num_rows  : first row and row count (0..DEPTH)
//   busy, done           : activity flag, one-cycle completion pulse
//   sram_re, sram_raddr  : SRAM read port request
//   sram_rdata           : SRAM read data, combinational with the request
//   out_if               : row stream (valid/data/last/ready)
module kv_tile_reader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [WIDTH-1:0]  sram_rdata,
    kv_tile_reader_if.master  out_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q;
    logic              last_q;
    logic              slot_free;
    logic              issue;
    logic              handshake;
    logic [ADDR_W-1:0] addr_next;

    // The output register can take a new row when it is empty or being drained
    // on this same edge, which gives back-to-back rows with no bubble.
    assign slot_free = !valid_q || out_if.out_ready;
    assign handshake = valid_q && out_if.out_ready;
    assign addr_next = (addr_q == ADDR_TOP) ? '0 : addr_q + ADDR_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (slot_free) begin
                    issue = 1'b1;
                    if (remaining_q == CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (handshake) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q      <= base_addr;
                remaining_q <= num_rows;
            end
            if (issue) begin
                data_q      <= sram_rdata;
                valid_q     <= 1'b1;
                last_q      <= (remaining_q == CNT_ONE);
                addr_q      <= addr_next;
                remaining_q <= remaining_q - CNT_ONE;
            end else if (handshake) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign sram_re    = issue;
    assign sram_raddr = addr_q;

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_kv_tile_reader.sv
// tb_kv_tile_reader
// Directed bench for kv_tile_reader with a 32x32 SRAM holding row i = i*0x11.
module tb_kv_tile_reader;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_rows;
    logic              busy;
    logic              done;
    logic              sram_re;
    logic [ADDR_W-1:0] sram_raddr;
    logic [WIDTH-1:0]  sram_rdata;

    logic [WIDTH-1:0]  mem [DEPTH];

    kv_tile_reader_if #(.WIDTH(WIDTH)) s_if ();

    kv_tile_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .busy       (busy),
        .done       (done),
        .sram_re    (sram_re),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .out_if     (s_if.master)
    );

    assign sram_rdata = mem[sram_raddr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0]  got_data [$];
    logic              got_last [$];
    logic [ADDR_W-1:0] got_addr [$];
    logic [WIDTH-1:0]  exp_data [$];
    logic [ADDR_W-1:0] exp_addr [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lands 1 time unit after the rising edge; inputs change here, outputs are
    // observed one unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_rows(input int base, input int n);
        exp_data.delete();
        exp_addr.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'((base + i) % DEPTH));
            exp_data.push_back(WIDTH'(((base + i) % DEPTH) * 32'h11));
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready follows 1,0,0,1,0,1,1 then 1.
    // inject_at >= 0 pulses start (base 9) on that cycle of the tile.
    task automatic run_stream(input int base, input int n, input int mode, input int inject_at);
        logic [6:0]       pat;
        logic             have_hold;
        logic [WIDTH-1:0] held;
        logic             finished;
        int               cyc;
        pat       = 7'b1101001;
        have_hold = 1'b0;
        held      = '0;
        finished  = 1'b0;
        cyc       = 0;
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        base_addr = ADDR_W'(base);
        num_rows  = (ADDR_W+1)'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        while (!finished && cyc < 200) begin
            s_if.out_ready = (mode == 1 && cyc < 7) ? pat[cyc] : 1'b1;
            if (cyc == inject_at) begin
                start     = 1'b1;
                base_addr = 5'd9;
                num_rows  = 6'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (have_hold) begin
                check("stall_valid", s_if.out_valid, 1'b1);
                check("stall_data", s_if.out_data, held);
            end
            have_hold = 1'b0;
            if (!s_if.out_valid) check("last_without_valid", s_if.out_last, 1'b0);
            if (sram_re) got_addr.push_back(sram_raddr);
            if (s_if.out_valid && s_if.out_ready) begin
                got_data.push_back(s_if.out_data);
                got_last.push_back(s_if.out_last);
            end
            if (s_if.out_valid && !s_if.out_ready) begin
                check("stall_no_read", sram_re, 1'b0);
                have_hold = 1'b1;
                held      = s_if.out_data;
            end
            if (done) finished = 1'b1;
            tick();
            cyc++;
        end
        start          = 1'b0;
        s_if.out_ready = 1'b1;
        check("done_seen", finished, 1'b1);
        check("idle_after_done", busy, 1'b0);
    endtask

    task automatic compare_seq(input string tag);
        check({tag, "_rows"}, 64'(got_data.size()), 64'(exp_data.size()));
        check({tag, "_reads"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], (i == exp_data.size() - 1));
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 32'h11);
        reset          = 1'b1;
        start          = 1'b0;
        base_addr      = '0;
        num_rows       = '0;
        s_if.out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", s_if.out_valid, 1'b0);
        check("rst_last", s_if.out_last, 1'b0);
        check("rst_re", sram_re, 1'b0);
        check("rst_data", s_if.out_data, 32'h0);
        reset = 1'b0;
        tick();

        // Basic stream, cycle-exact: base 3, four rows, sink always ready.
        base_addr = 5'd3;
        num_rows  = 6'd4;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("b_c1_re", sram_re, 1'b1);
        check("b_c1_addr", sram_raddr, 5'd3);
        check("b_c1_valid", s_if.out_valid, 1'b0);
        check("b_c1_busy", busy, 1'b1);
        tick();
        check("b_c2_valid", s_if.out_valid, 1'b1);
        check("b_c2_data", s_if.out_data, 32'h33);
        check("b_c2_last", s_if.out_last, 1'b0);
        tick();
        check("b_c3_data", s_if.out_data, 32'h44);
        tick();
        check("b_c4_data", s_if.out_data, 32'h55);
        check("b_c4_last", s_if.out_last, 1'b0);
        tick();
        check("b_c5_data", s_if.out_data, 32'h66);
        check("b_c5_last", s_if.out_last, 1'b1);
        check("b_c5_re", sram_re, 1'b0);
        tick();
        check("b_c6_done", done, 1'b1);
        check("b_c6_valid", s_if.out_valid, 1'b0);
        check("b_c6_busy", busy, 1'b1);
        tick();
        check("b_c7_done", done, 1'b0);
        check("b_c7_busy", busy, 1'b0);

        // Backpressure on the same tile.
        run_stream(3, 4, 1, -1);
        expect_rows(3, 4);
        compare_seq("bp");

        // Address wrap: 30, 31, 0, 1.
        run_stream(30, 4, 0, -1);
        expect_rows(30, 4);
        compare_seq("wrap");

        // Zero-length tile.
        base_addr = 5'd7;
        num_rows  = 6'd0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("z_done", done, 1'b1);
        check("z_re", sram_re, 1'b0);
        check("z_valid", s_if.out_valid, 1'b0);
        tick();
        check("z_done_off", done, 1'b0);
        check("z_busy", busy, 1'b0);
        check("z_valid2", s_if.out_valid, 1'b0);

        // Full-depth tile starting mid-array.
        run_stream(5, 32, 0, -1);
        expect_rows(5, 32);
        compare_seq("full");

        // start pulsed mid-tile must be ignored.
        run_stream(3, 4, 1, 2);
        expect_rows(3, 4);
        compare_seq("sbusy");

        // Reset after the second row is presented.
        base_addr = 5'd3;
        num_rows  = 6'd4;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        tick();
        check("r_row2_valid", s_if.out_valid, 1'b1);
        check("r_row2_data", s_if.out_data, 32'h44);
        reset = 1'b1;
        tick();
        check("r_valid", s_if.out_valid, 1'b0);
        check("r_busy", busy, 1'b0);
        check("r_done", done, 1'b0);
        check("r_re", sram_re, 1'b0);
        check("r_data", s_if.out_data, 32'h0);
        reset = 1'b0;
        tick();
        check("r_idle_valid", s_if.out_valid, 1'b0);
        run_stream(20, 2, 0, -1);
        expect_rows(20, 2);
        compare_seq("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kv_tile_reader.md
Name: kv_tile_reader

Overview:
Sequencer directly downstream of the dual-ported on-chip tile SRAM. On a start command it reads a contiguous run of rows (K or V vectors) from the SRAM read port and presents them as a valid/ready stream to the attention datapath (QK dot-product / PV accumulate). It generates SRAM addresses, absorbs downstream backpressure with a single output register, and reports completion.

Parameters:
WIDTH, 32, row width in bits; must match the SRAM WIDTH.
DEPTH, 32, SRAM depth in rows; must match the SRAM DEPTH.
ADDR_W, $clog2(DEPTH), address width (derived; do not override).

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin a tile read; sampled only in IDLE
base_addr  input  ADDR_W  first SRAM row to read
num_rows  input  ADDR_W+1  rows to stream, 0..DEPTH
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse after the final row handshakes
sram_re  output  1  SRAM read enable (single read port)
sram_raddr  output  ADDR_W  SRAM read address
sram_rdata  input  WIDTH  SRAM read data; combinational, same cycle as sram_re/sram_raddr, no bypass dependence
out_valid  output  1  out_data holds a row
out_data  output  WIDTH  row data, registered
out_last  output  1  qualifies out_data as the final row of the tile
out_ready  input  1  downstream accepts the row when out_valid && out_ready

Behaviour:
- Reset (synchronous; asserting it mid-tile aborts): state=IDLE. busy, done, out_valid, out_last and sram_re are 0. out_data, the address register and the remaining-row counter are 0. No row is emitted after reset.
- States:
  - IDLE -> LOAD when start=1 and num_rows!=0. The block latches addr=base_addr and remaining=num_rows.
  - IDLE -> FINISH when start=1 and num_rows=0. No SRAM access and no output.
  - LOAD: issues reads. When remaining reaches 0 after an issue, -> DRAIN.
  - DRAIN: waits for the final handshake, then -> FINISH.
  - FINISH: done=1 for exactly one cycle, then -> IDLE.
- start is ignored in any state other than IDLE. Parameters are not re-latched mid-tile.
- Issue rule: in LOAD, a slot is free when (!out_valid || out_ready). When a slot is free:
  - sram_re=1 and sram_raddr=addr.
  - At the clock edge: out_data<=sram_rdata, out_valid<=1, out_last<=(remaining==1), addr<=addr+1 mod DEPTH, remaining<=remaining-1.
- When no slot is free, sram_re=0 and the address and counter hold. sram_raddr is a don't-care whenever sram_re=0; drive it with addr.
- Handshake:
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_valid drops the cycle after a handshake unless a new row loads on the same edge.
  - Back-to-back throughput is one row per cycle when out_ready is held high.
- Latency: start sampled at edge E0. First sram_re occurs in the cycle after E0. out_valid rises after edge E1. done asserts in the cycle after the handshake that carries out_last.
- Address wrap: addr increments modulo DEPTH. base_addr=DEPTH-2 with num_rows=4 reads DEPTH-2, DEPTH-1, 0, 1.
- num_rows=DEPTH reads every row exactly once.
- Simultaneous events in LOAD with out_valid && out_ready: the handshake and the next load occur on the same edge with no bubble.
- In DRAIN the block issues no reads; out_valid falls on the final handshake edge.
- out_last is 1 only on the final row. It is 0 whenever out_valid=0.

Test Plan:
- Basic stream: SRAM rows r[i]=i*0x11; base_addr=3, num_rows=4, out_ready=1. Required: out_data 0x33, 0x44, 0x55, 0x66 on 4 consecutive cycles, starting 2 cycles after start. out_last only with 0x66. done pulses one cycle after that, then busy=0.
- Backpressure: same tile, with out_ready toggling 1,0,0,1,0,1,1. Required: no row dropped or duplicated, out_data stable while stalled, sram_re=0 on stalled cycles.
- Wrap: DEPTH=32, base_addr=30, num_rows=4. Required: sram_raddr sequence 30, 31, 0, 1, and data matches those rows.
- Zero and full length: num_rows=0 gives done one cycle after start, with out_valid and sram_re never asserted. num_rows=32 gives exactly 32 handshakes covering all addresses.
- start while busy: pulse start with base_addr=9 mid-tile. Required: it is ignored and the original sequence continues unchanged.
- Reset mid-operation: assert reset after the 2nd row with out_valid=1. Required: next cycle out_valid=0, busy=0, done=0. A new start then streams correctly from its own base_addr.
